// File: rtl/tengigeth_loop_tester.sv
// Loopback initiator: sends numbered test frames on the L3->L2 stream and checks the
// MAC-swapped copies returned on the L2->L3 stream, keeping TX/RX/error counts.
//
// state      | meaning
// TX_IDLE    | waiting for an accepted start pulse
// TX_SEND    | streaming frame beats, back-to-back until cnt frames are sent
// TX_WAIT    | all frames sent; waiting for RX to catch up or for the quiet timeout
// RX_HDR0    | expecting beat 0: dst MAC and first two src MAC bytes
// RX_HDR1    | expecting beat 1: rest of src MAC, EtherType, sequence number
// RX_PAYLOAD | checking pattern bytes, length and last-beat byte enables
// RX_DROP    | discarding until tlast (foreign frame, or test frame missing tlast)
module tengigeth_loop_tester #(
    parameter logic [47:0] gLocalMac  = 48'h0A0B0C0D0E0F,
    parameter logic [47:0] gPeerMac   = 48'h001122334455,
    parameter logic [15:0] gEtherType = 16'h88B5,
    parameter int unsigned gTimeout   = 1024
) (
    input  logic        piEthCoreClk,
    input  logic        piEthCoreRst,
    input  logic        piStart,
    input  logic [10:0] piFrameLen,
    input  logic [15:0] piFrameCnt,
    output logic [63:0] po_Axis_tdata,
    output logic [7:0]  po_Axis_tkeep,
    output logic        po_Axis_tlast,
    output logic        po_Axis_tvalid,
    input  logic        pi_Axis_tready,
    input  logic [63:0] pi_Axis_tdata,
    input  logic [7:0]  pi_Axis_tkeep,
    input  logic        pi_Axis_tlast,
    input  logic        pi_Axis_tvalid,
    output logic        po_Axis_tready,
    output logic        poBusy,
    output logic        poDone,
    output logic [15:0] poTxFrames,
    output logic [15:0] poRxFrames,
    output logic [15:0] poErrCnt
);

    localparam int unsigned TMO_W = (gTimeout > 1) ? $clog2(gTimeout) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(gTimeout - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
    typedef enum logic [1:0] {RX_HDR0, RX_HDR1, RX_PAYLOAD, RX_DROP} rx_state_t;

    function automatic logic [7:0] lane_mask(input logic [3:0] n);
        logic [7:0] m;
        for (int l = 0; l < 8; l++) begin
            m[l] = (4'(l) < n);
        end
        return m;
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [127:0] hdr, input logic [3:0] i);
        return hdr[8*(15 - int'(i)) +: 8];
    endfunction

    tx_state_t        tx_state_q, tx_state_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [10:0]      len_q, len_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       beat_q, beat_d;
    logic [15:0]      tx_frames_q, tx_frames_d;
    logic [15:0]      rx_frames_q, rx_frames_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rdy_q;
    logic [10:0]      rx_bcnt_q, rx_bcnt_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_drop_cnt_q, rx_drop_cnt_d;

    logic [127:0] tx_hdr;
    logic [10:0]  tx_len_m1;
    logic         tx_last_beat;
    logic [7:0]   tx_last_keep;
    logic         tx_valid;
    logic [10:0]  tx_idx;
    logic [7:0]   tx_byte;

    logic         rx_beat;
    logic [127:0] rx_hdr;
    logic [10:0]  rx_rem;
    logic         rx_last_exp;
    logic [7:0]   rx_exp_keep;
    logic [10:0]  rx_idx;
    logic [7:0]   rx_exp_byte;
    logic         rx_mism;
    logic         rx_etype_ok;
    logic         rx_done;
    logic         rx_bad;

    // TX beat generation: header bytes from a 128-bit big-endian image, then the seq-offset pattern
    always_comb begin
        tx_hdr       = {gPeerMac, gLocalMac, gEtherType, tx_frames_q};
        tx_len_m1    = len_q - 11'd1;
        tx_last_beat = (beat_q == tx_len_m1[10:3]);
        tx_last_keep = lane_mask({1'b0, tx_len_m1[2:0]} + 4'd1);
        tx_valid     = (tx_state_q == TX_SEND);
        tx_idx       = 11'd0;
        tx_byte      = 8'd0;
        po_Axis_tdata = 64'd0;
        for (int l = 0; l < 8; l++) begin
            tx_idx  = {beat_q, 3'(l)};
            tx_byte = (tx_idx < 11'd16) ? hdr_byte(tx_hdr, tx_idx[3:0])
                                        : tx_frames_q[7:0] + tx_idx[7:0];
            if (tx_valid && (!tx_last_beat || tx_last_keep[l])) begin
                po_Axis_tdata[8*l +: 8] = tx_byte;
            end
        end
        po_Axis_tkeep  = tx_valid ? (tx_last_beat ? tx_last_keep : 8'hFF) : 8'h00;
        po_Axis_tlast  = tx_valid && tx_last_beat;
        po_Axis_tvalid = tx_valid;
    end

    // RX checker: byte index tracked by rx_bcnt_q, header and payload expectations unified
    always_comb begin
        rx_beat       = pi_Axis_tvalid && rdy_q;
        rx_hdr        = {gLocalMac, gPeerMac, gEtherType, rx_frames_q};
        rx_rem        = len_q - rx_bcnt_q;
        rx_last_exp   = (rx_rem <= 11'd8);
        rx_exp_keep   = (rx_rem >= 11'd8) ? 8'hFF : lane_mask(rx_rem[3:0]);
        rx_etype_ok   = ({pi_Axis_tdata[39:32], pi_Axis_tdata[47:40]} == gEtherType);
        rx_idx        = 11'd0;
        rx_exp_byte   = 8'd0;
        rx_mism       = 1'b0;
        for (int l = 0; l < 8; l++) begin
            rx_idx      = rx_bcnt_q + 11'(l);
            rx_exp_byte = (rx_idx < 11'd16) ? hdr_byte(rx_hdr, rx_idx[3:0])
                                            : rx_frames_q[7:0] + rx_idx[7:0];
            if (pi_Axis_tkeep[l] && (pi_Axis_tdata[8*l +: 8] != rx_exp_byte)) begin
                rx_mism = 1'b1;
            end
        end

        rx_state_d    = rx_state_q;
        rx_bcnt_d     = rx_bcnt_q;
        rx_err_d      = rx_err_q;
        rx_drop_cnt_d = rx_drop_cnt_q;
        rx_done       = 1'b0;
        rx_bad        = 1'b0;

        if (rx_beat) begin
            case (rx_state_q)
                RX_HDR0: begin
                    if (pi_Axis_tlast) begin
                        rx_done   = 1'b1;
                        rx_bad    = 1'b1;
                        rx_bcnt_d = 11'd0;
                    end else begin
                        rx_err_d   = rx_mism || (pi_Axis_tkeep != 8'hFF);
                        rx_bcnt_d  = 11'd8;
                        rx_state_d = RX_HDR1;
                    end
                end
                RX_HDR1: begin
                    if (!rx_etype_ok) begin
                        rx_err_d      = 1'b0;
                        rx_drop_cnt_d = 1'b0;
                        rx_bcnt_d     = 11'd0;
                        rx_state_d    = pi_Axis_tlast ? RX_HDR0 : RX_DROP;
                    end else if (pi_Axis_tlast) begin
                        rx_done    = 1'b1;
                        rx_bad     = 1'b1;
                        rx_bcnt_d  = 11'd0;
                        rx_state_d = RX_HDR0;
                    end else begin
                        rx_err_d   = rx_err_q || rx_mism || (pi_Axis_tkeep != 8'hFF);
                        rx_bcnt_d  = 11'd16;
                        rx_state_d = RX_PAYLOAD;
                    end
                end
                RX_PAYLOAD: begin
                    if (pi_Axis_tlast) begin
                        rx_done    = 1'b1;
                        rx_bad     = !rx_last_exp || rx_err_q || rx_mism ||
                                     (pi_Axis_tkeep != rx_exp_keep);
                        rx_bcnt_d  = 11'd0;
                        rx_state_d = RX_HDR0;
                    end else if (rx_last_exp) begin
                        rx_err_d      = 1'b1;
                        rx_drop_cnt_d = 1'b1;
                        rx_bcnt_d     = 11'd0;
                        rx_state_d    = RX_DROP;
                    end else begin
                        rx_err_d  = rx_err_q || rx_mism || (pi_Axis_tkeep != 8'hFF);
                        rx_bcnt_d = rx_bcnt_q + 11'd8;
                    end
                end
                default: begin
                    if (pi_Axis_tlast) begin
                        rx_done    = rx_drop_cnt_q;
                        rx_bad     = rx_drop_cnt_q;
                        rx_bcnt_d  = 11'd0;
                        rx_state_d = RX_HDR0;
                    end
                end
            endcase
        end
    end

    // TX sequencing, completion detection and the shared counters
    always_comb begin
        tx_state_d  = tx_state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        tx_frames_d = tx_frames_q;
        rx_frames_d = rx_frames_q;
        err_cnt_d   = err_cnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        tmo_d       = tmo_q;

        if (rx_done) begin
            rx_frames_d = rx_frames_q + 16'd1;
            if (rx_bad && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        if ((tx_state_q != TX_WAIT) || rx_beat) begin
            tmo_d = TMO_LOAD;
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (piStart) begin
                    if (piFrameLen < 11'd60) begin
                        len_d = 11'd60;
                    end else if (piFrameLen > 11'd1514) begin
                        len_d = 11'd1514;
                    end else begin
                        len_d = piFrameLen;
                    end
                    cnt_d       = piFrameCnt;
                    beat_d      = 8'd0;
                    tx_frames_d = 16'd0;
                    rx_frames_d = 16'd0;
                    err_cnt_d   = 16'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    tx_state_d  = (piFrameCnt == 16'd0) ? TX_WAIT : TX_SEND;
                end
            end
            TX_SEND: begin
                if (pi_Axis_tready) begin
                    if (tx_last_beat) begin
                        beat_d      = 8'd0;
                        tx_frames_d = tx_frames_q + 16'd1;
                        if ((tx_frames_q + 16'd1) == cnt_q) begin
                            tx_state_d = TX_WAIT;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: begin
                if ((rx_frames_q == cnt_q) || ((tmo_q == '0) && !rx_beat)) begin
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge piEthCoreClk or posedge piEthCoreRst) begin
        if (piEthCoreRst) begin
            tx_state_q    <= TX_IDLE;
            rx_state_q    <= RX_HDR0;
            len_q         <= 11'd60;
            cnt_q         <= 16'd0;
            beat_q        <= 8'd0;
            tx_frames_q   <= 16'd0;
            rx_frames_q   <= 16'd0;
            err_cnt_q     <= 16'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tmo_q         <= TMO_LOAD;
            rdy_q         <= 1'b0;
            rx_bcnt_q     <= 11'd0;
            rx_err_q      <= 1'b0;
            rx_drop_cnt_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            rx_state_q    <= rx_state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            tx_frames_q   <= tx_frames_d;
            rx_frames_q   <= rx_frames_d;
            err_cnt_q     <= err_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tmo_q         <= tmo_d;
            rdy_q         <= 1'b1;
            rx_bcnt_q     <= rx_bcnt_d;
            rx_err_q      <= rx_err_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
        end
    end

    assign po_Axis_tready = rdy_q;
    assign poBusy         = busy_q;
    assign poDone         = done_q;
    assign poTxFrames     = tx_frames_q;
    assign poRxFrames     = rx_frames_q;
    assign poErrCnt       = err_cnt_q;

endmodule

// File: tb/tb_tengigeth_loop_tester.sv
// Directed bench: TX stream is captured, MAC-swapped (optionally corrupted/dropped) and
// replayed into the RX port; counters, beat shapes and header bytes are checked.
`timescale 1ns/1ps
module tb_tengigeth_loop_tester;

    logic        clk;
    logic        rst;
    logic        piStart;
    logic [10:0] piFrameLen;
    logic [15:0] piFrameCnt;
    logic [63:0] po_tdata;
    logic [7:0]  po_tkeep;
    logic        po_tlast;
    logic        po_tvalid;
    logic        pi_tready;
    logic [63:0] pi_tdata;
    logic [7:0]  pi_tkeep;
    logic        pi_tlast;
    logic        pi_tvalid;
    logic        po_tready;
    logic        poBusy;
    logic        poDone;
    logic [15:0] poTxFrames;
    logic [15:0] poRxFrames;
    logic [15:0] poErrCnt;

    tengigeth_loop_tester dut (
        .piEthCoreClk   (clk),
        .piEthCoreRst   (rst),
        .piStart        (piStart),
        .piFrameLen     (piFrameLen),
        .piFrameCnt     (piFrameCnt),
        .po_Axis_tdata  (po_tdata),
        .po_Axis_tkeep  (po_tkeep),
        .po_Axis_tlast  (po_tlast),
        .po_Axis_tvalid (po_tvalid),
        .pi_Axis_tready (pi_tready),
        .pi_Axis_tdata  (pi_tdata),
        .pi_Axis_tkeep  (pi_tkeep),
        .pi_Axis_tlast  (pi_tlast),
        .pi_Axis_tvalid (pi_tvalid),
        .po_Axis_tready (po_tready),
        .poBusy         (poBusy),
        .poDone         (poDone),
        .poTxFrames     (poTxFrames),
        .poRxFrames     (poRxFrames),
        .poErrCnt       (poErrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] cap_buf [0:2047];
    logic [7:0] rxbuf [0:15][0:2047];
    int         rx_len [0:15];
    int         rx_q [$];
    int         cap_n = 0;
    int         cap_beats = 0;
    int         last_beats = 0;
    logic [7:0] last_keep = 8'h00;
    int         tx_fidx = 0;
    int         start_req = 0;
    int         start_seen = 0;
    bit         throttle = 0;
    int         corrupt_seq = -1;
    int         corrupt_byte = 0;
    int         drop_seq = -1;
    bit         stalled = 0;
    logic [79:0] stall_snap = '0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX capture + MAC-swap loopback model; also checks output hold during back-pressure
    initial begin
        pi_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (start_req != start_seen) begin
                start_seen = start_req;
                tx_fidx    = 0;
                cap_n      = 0;
                cap_beats  = 0;
            end
            if (rst) begin
                cap_n     = 0;
                cap_beats = 0;
                stalled   = 0;
            end else begin
                if (stalled)
                    check("tx_stall_hold", {6'b0, po_tvalid, po_tlast, po_tkeep, po_tdata}, stall_snap);
                pi_tready = throttle ? ($urandom_range(0, 99) >= 30) : 1'b1;
                if (po_tvalid && pi_tready) begin
                    stalled = 0;
                    for (int l = 0; l < 8; l++) begin
                        if (po_tkeep[l]) begin
                            cap_buf[cap_n] = po_tdata[8*l +: 8];
                            cap_n++;
                        end
                    end
                    cap_beats++;
                    if (po_tlast) begin
                        for (int j = 0; j < cap_n; j++)
                            rxbuf[tx_fidx % 16][j] = (j < 6) ? cap_buf[j+6] :
                                                     (j < 12) ? cap_buf[j-6] : cap_buf[j];
                        if (tx_fidx == corrupt_seq)
                            rxbuf[tx_fidx % 16][corrupt_byte] = rxbuf[tx_fidx % 16][corrupt_byte] ^ 8'hFF;
                        rx_len[tx_fidx % 16] = cap_n;
                        last_beats = cap_beats;
                        last_keep  = po_tkeep;
                        if (tx_fidx != drop_seq) rx_q.push_back(tx_fidx % 16);
                        tx_fidx++;
                        cap_n     = 0;
                        cap_beats = 0;
                    end
                end else begin
                    stalled    = po_tvalid;
                    stall_snap = {6'b0, po_tvalid, po_tlast, po_tkeep, po_tdata};
                end
            end
        end
    end

    // RX replay driver
    initial begin
        int  rx_slot;
        int  rx_pos;
        bit  rx_active;
        rx_slot   = 0;
        rx_pos    = 0;
        rx_active = 0;
        pi_tvalid = 1'b0;
        pi_tlast  = 1'b0;
        pi_tkeep  = 8'h00;
        pi_tdata  = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_q.delete();
                rx_active = 0;
                pi_tvalid = 1'b0;
                pi_tlast  = 1'b0;
                pi_tkeep  = 8'h00;
                pi_tdata  = 64'd0;
            end else begin
                if (!rx_active && rx_q.size() > 0) begin
                    rx_slot   = rx_q.pop_front();
                    rx_pos    = 0;
                    rx_active = 1;
                end
                if (rx_active && po_tready) begin
                    for (int l = 0; l < 8; l++) begin
                        if (rx_pos + l < rx_len[rx_slot]) begin
                            pi_tdata[8*l +: 8] = rxbuf[rx_slot][rx_pos + l];
                            pi_tkeep[l]        = 1'b1;
                        end else begin
                            pi_tdata[8*l +: 8] = 8'h00;
                            pi_tkeep[l]        = 1'b0;
                        end
                    end
                    pi_tlast  = (rx_pos + 8 >= rx_len[rx_slot]);
                    pi_tvalid = 1'b1;
                    rx_pos    = rx_pos + 8;
                    if (pi_tlast) rx_active = 0;
                end else begin
                    pi_tvalid = 1'b0;
                    pi_tlast  = 1'b0;
                end
            end
        end
    end

    task automatic start_test(input logic [10:0] len, input logic [15:0] cnt);
        start_req++;
        @(negedge clk);
        piFrameLen = len;
        piFrameCnt = cnt;
        piStart    = 1'b1;
        @(negedge clk);
        piStart    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int c;
        c = 0;
        while (!poDone && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(tag, poDone, 1'b1);
    endtask

    initial begin
        int bad;
        int c;
        rst        = 1'b1;
        piStart    = 1'b0;
        piFrameLen = 11'd0;
        piFrameCnt = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_bus", {po_tvalid, po_tlast, po_tkeep, po_tdata}, 80'd0);
        check("rst_rx_ready", po_tready, 1'b0);
        check("rst_status", {poBusy, poDone}, 2'b00);
        check("rst_counts", {poTxFrames, poRxFrames, poErrCnt}, 48'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rx_ready_after_rst", po_tready, 1'b1);

        // len 64, 4 frames, unthrottled
        start_test(11'd64, 16'd4);
        check("a_first_valid", {po_tvalid, poBusy, poDone}, 3'b110);
        check("a_beat0", po_tdata, 64'h0B0A_5544_3322_1100);
        @(negedge clk);
        check("a_beat1", po_tdata, 64'h0000_B588_0F0E_0D0C);
        wait_done("a_done", 5000);
        check("a_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd4, 16'd4, 16'd0});
        check("a_busy_clear", poBusy, 1'b0);
        check("a_shape", {last_beats[7:0], last_keep}, {8'd8, 8'hFF});

        // len 61, 2 frames
        start_test(11'd61, 16'd2);
        wait_done("b_done", 5000);
        check("b_shape", {last_beats[7:0], last_keep}, {8'd8, 8'h1F});
        check("b_f1_byte16", rxbuf[1][16], 8'h11);
        check("b_f1_byte15", rxbuf[1][15], 8'h01);
        bad = 0;
        for (int i = 16; i < 61; i++)
            if (rxbuf[1][i] !== 8'(1 + i)) bad++;
        check("b_f1_pattern_errs", bad, 0);
        check("b_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd2, 16'd2, 16'd0});

        // length clamping
        start_test(11'd20, 16'd1);
        wait_done("c1_done", 5000);
        check("c1_shape", {last_beats[7:0], last_keep}, {8'd8, 8'h0F});
        check("c1_len", rx_len[0], 60);
        check("c1_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd1, 16'd1, 16'd0});
        start_test(11'd2000, 16'd1);
        wait_done("c2_done", 5000);
        check("c2_shape", {last_beats[7:0], last_keep}, {8'd190, 8'h03});
        check("c2_len", rx_len[0], 1514);
        check("c2_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd1, 16'd1, 16'd0});

        // 30% tready throttling
        throttle = 1;
        start_test(11'd64, 16'd10);
        wait_done("d_done", 20000);
        throttle = 0;
        check("d_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd10, 16'd10, 16'd0});

        // corrupt byte 40 of seq 1 (2nd frame), drop seq 4 (5th frame)
        corrupt_seq  = 1;
        corrupt_byte = 40;
        drop_seq     = 4;
        start_test(11'd64, 16'd8);
        c = 0;
        while (poRxFrames != 16'd7 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("e_rx_seven", poRxFrames, 16'd7);
        repeat (200) @(negedge clk);
        check("e_still_waiting", {poBusy, poDone}, 2'b10);
        wait_done("e_done_after_timeout", 3000);
        corrupt_seq = -1;
        drop_seq    = -1;
        check("e_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd8, 16'd7, 16'd4});

        // reset mid-frame, then a single-frame test with an ignored second start
        start_test(11'd1514, 16'd3);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("f_rst_tx_bus", {po_tvalid, po_tlast, po_tkeep, po_tdata}, 80'd0);
        check("f_rst_status", {po_tready, poBusy, poDone}, 3'b000);
        check("f_rst_counts", {poTxFrames, poRxFrames, poErrCnt}, 48'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_test(11'd64, 16'd1);
        repeat (2) @(negedge clk);
        piFrameLen = 11'd2000;
        piFrameCnt = 16'd5;
        piStart    = 1'b1;
        @(negedge clk);
        piStart    = 1'b0;
        check("f_busy_kept", {poBusy, poDone}, 2'b10);
        wait_done("f_done", 5000);
        check("f_counts", {poTxFrames, poRxFrames, poErrCnt}, {16'd1, 16'd1, 16'd0});
        check("f_shape", {last_beats[7:0], last_keep}, {8'd8, 8'hFF});
        repeat (20) @(negedge clk);
        check("f_idle_after", {po_tvalid, poBusy, poTxFrames}, {1'b0, 1'b0, 16'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
